// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot timebase, frame-aligned double-buffered
// display data, brightness window, leading-zero suppression and blinking.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYC    = 1_000,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     digit,
  output logic                  frame_start,
  output logic                  upd_done
);

  localparam int TW      = $clog2(SCAN_DIV);
  localparam int SW      = $clog2(DIGITS);
  localparam int BW      = $clog2(BLINK_FRAMES) + 1;
  localparam int ON_FULL = SCAN_DIV - BLANK_CYC;
  localparam int ON_STEP = ON_FULL / 16;

  // Scan timebase releases on the first edge so frame 0 starts at once; the
  // load/data path leaves reset through a two-flop release synchroniser.
  logic [1:0] rst_pipe;
  logic       data_rst_n;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign data_rst_n = rst_pipe[1];

  logic [TW-1:0] timer;
  logic [SW-1:0] slot;
  logic [BW-1:0] bcnt;
  logic          blink_phase;
  logic          timer_wrap, slot_wrap, boundary, frame_end;

  assign timer_wrap = (timer == TW'(SCAN_DIV - 1));
  assign slot_wrap  = (slot == SW'(DIGITS - 1));
  assign boundary   = (timer == '0) && (slot == '0);
  assign frame_end  = timer_wrap && slot_wrap;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      timer       <= '0;
      slot        <= '0;
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else begin
      timer <= timer_wrap ? '0 : timer + 1'b1;
      if (timer_wrap) slot <= slot_wrap ? '0 : slot + 1'b1;
      if (frame_end) begin
        if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // load is a single-cycle strobe with no back-pressure: every cycle it is high
  // is captured, mid-frame into the pending copy, on a boundary straight to display.
  logic [4*DIGITS-1:0] disp_val, pend_val, nxt_val;
  logic [DIGITS-1:0]   disp_dp, pend_dp, nxt_dp;
  logic [DIGITS-1:0]   disp_blk, pend_blk, nxt_blk;
  logic                pend, load_ok;

  assign load_ok = load && data_rst_n;

  always_comb begin
    nxt_val = disp_val;
    nxt_dp  = disp_dp;
    nxt_blk = disp_blk;
    if (boundary) begin
      if (load_ok) begin
        nxt_val = value_in;
        nxt_dp  = dp_in;
        nxt_blk = blink_mask;
      end else if (pend) begin
        nxt_val = pend_val;
        nxt_dp  = pend_dp;
        nxt_blk = pend_blk;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge data_rst_n) begin
    if (!data_rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
      disp_blk <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_blk <= '0;
      pend     <= 1'b0;
      upd_done <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      disp_val <= nxt_val;
      disp_dp  <= nxt_dp;
      disp_blk <= nxt_blk;
      if (boundary) begin
        if (load_ok || pend) upd_done <= 1'b1;
        pend <= 1'b0;
      end else if (load_ok) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
        pend_blk <= blink_mask;
        pend     <= 1'b1;
      end
    end
  end

  // Rendering uses nxt_* so the boundary cycle already shows the new frame's data.
  logic [DIGITS-1:0] sup;
  always_comb begin
    logic run;
    run = lz_en;
    sup = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run    = run && (nxt_val[4*i +: 4] == 4'h0);
      sup[i] = run && (i != 0);
    end
  end

  int                slot_idx;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blk, cur_sup;
  logic [DIGITS-1:0] dsel;

  assign slot_idx = DIGITS - 1 - int'(slot);

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    cur_sup = 1'b0;
    dsel    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == slot_idx) begin
        cur_nib = nxt_val[4*i +: 4];
        cur_dp  = nxt_dp[i];
        cur_blk = nxt_blk[i];
        cur_sup = sup[i];
        dsel[i] = 1'b0;
      end
    end
  end

  logic [TW:0] on_len;
  logic        on_win, blink_off;

  always_comb begin
    on_len = (bright == 4'hF) ? (TW+1)'(ON_FULL) : (TW+1)'(ON_STEP * (int'(bright) + 1));
    on_win = ({1'b0, timer} >= (TW+1)'(BLANK_CYC)) &&
             ({1'b0, timer} < ((TW+1)'(BLANK_CYC) + on_len));
  end

  assign blink_off = blink_phase && cur_blk;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] abcdefg;
    logic [6:0] res;
    case (nib)
      4'h0:    abcdefg = 7'b0000001;
      4'h1:    abcdefg = 7'b1001111;
      4'h2:    abcdefg = 7'b0010010;
      4'h3:    abcdefg = 7'b0000110;
      4'h4:    abcdefg = 7'b1001100;
      4'h5:    abcdefg = 7'b0100100;
      4'h6:    abcdefg = 7'b0100000;
      4'h7:    abcdefg = 7'b0001111;
      4'h8:    abcdefg = 7'b0000000;
      4'h9:    abcdefg = 7'b0000100;
      4'hA:    abcdefg = 7'b0001000;
      4'hB:    abcdefg = 7'b1100000;
      4'hC:    abcdefg = 7'b0110001;
      4'hD:    abcdefg = 7'b1000010;
      4'hE:    abcdefg = 7'b0110000;
      default: abcdefg = 7'b0111000;
    endcase
    if (nib > 4'h9 && HEX_MODE == 0) abcdefg = 7'b1111111;
    // Table is written a..g left to right; the port carries a in bit 0.
    for (int k = 0; k < 7; k++) res[k] = abcdefg[6-k];
    return res;
  endfunction

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      digit       <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (on_win) begin
        digit <= dsel;
        seg   <= (cur_sup || blink_off) ? 7'h7F : seg_decode(cur_nib);
        dp_n  <= blink_off ? 1'b1 : ~cur_dp;
      end else begin
        digit <= '1;
        seg   <= 7'h7F;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule
